mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control unit sitting directly upstream of the datapath.
- Consumes the datapath's `Instruction_class` (opcode), `func` and `ZERO`; drives every datapath control input, plus PC and IR write enables.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB so PC, GRF and DM update once per instruction.
- Supports addu, subu, ori, lui, lw, sw, beq, jal, jr, nop.

Parameters:
- `RESET_STATE`, 3'd0, state entered on reset (FETCH).

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `Instruction_class`  input  6  opcode field from datapath IR; valid from DECODE onward.
- `func`  input  6  funct field from datapath IR; valid from DECODE onward.
- `ZERO`  input  1  ALU equality flag, valid in EXEC.
- `PCWrite`  output  1  PC register load enable.
- `IRWrite`  output  1  instruction register load enable.
- `RegWrite`  output  1  GRF write enable.
- `MemRead`  output  1  DM write strobe (existing datapath name).
- `MemtoReg`  output  2  00 ALU, 01 DM, 10 PC4.
- `ALU_SRC`  output  1  0 read2, 1 extended imm.
- `ALUop`  output  4  0 add, 1 sub, 2 or, 3 lui (imm<<16).
- `RegDst`  output  2  00 rt, 01 rd, 10 $31.
- `NPCop`  output  2  00 PC+4, 01 branch, 10 jal, 11 jr.
- `EXTop`  output  1  0 zero-extend, 1 sign-extend.
- `newsign`  output  1  tied 0; reserved.
- `state`  output  3  current FSM state, for debug.
- `illegal`  output  1  one-cycle pulse on an undecodable instruction.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 return to FETCH on the next edge with all enables 0.
- Outputs are Moore-decoded from the registered state and the registered instruction type `itype` (latched at the end of DECODE).
- Reset:
  - state=FETCH, `itype`=NOP.
  - All enables and `illegal` are 0, all selects are 0.
  - Reset takes priority over any transition. Reset asserted mid-instruction aborts it; no partial PCWrite/RegWrite/MemRead occurs in the reset cycle.
- FETCH: `IRWrite`=1, then go to DECODE.
- DECODE: classify the opcode/func and latch `itype`.
  - Unknown opcode, or R-type with an unknown func: `illegal`=1 for this cycle, `PCWrite`=1 with `NPCop`=00 (skip the instruction), go to FETCH.
  - nop (opcode 0, func 0): treated identically to the unknown case but with `illegal`=0.
  - Otherwise go to EXEC.
- EXEC:
  - addu/subu/ori/lui/lw/sw: drive `ALU_SRC`/`ALUop`/`EXTop`, go to MEM (lw/sw) or WB (others).
  - beq: `ALUop`=sub, `EXTop`=1, `PCWrite`=1, `NPCop`=(ZERO?01:00), go to FETCH.
  - jal: `RegWrite`=1, `RegDst`=10, `MemtoReg`=10, `PCWrite`=1, `NPCop`=10, go to FETCH.
  - jr: `PCWrite`=1, `NPCop`=11, go to FETCH.
- MEM:
  - sw: `MemRead`=1, `EXTop`=1, `ALU_SRC`=1, `PCWrite`=1, `NPCop`=00, go to FETCH.
  - lw: hold the address selects, go to WB.
- WB:
  - `RegWrite`=1 and `PCWrite`=1 with `NPCop`=00.
  - R-type: `RegDst`=01, `MemtoReg`=00.
  - ori/lui: `RegDst`=00, `MemtoReg`=00.
  - lw: `RegDst`=00, `MemtoReg`=01.
  - Go to FETCH.
- ALU selects are held stable from EXEC through WB, so the combinational datapath result persists.
- Latencies, in cycles from FETCH to the next FETCH:
  - beq/jal/jr: 3.
  - sw and R-type/ori/lui: 4.
  - lw: 5.
  - nop and illegal: 2.
- At most one of `PCWrite`, `IRWrite` per cycle. `PCWrite` is asserted exactly once per instruction, in its final state.
- `newsign` is constant 0.

Optional Feature:
- Macro: `MC_CTRL_PERF_EN`.
- When defined, add outputs `cyc_cnt[31:0]` and `ins_cnt[31:0]`:
  - `cyc_cnt` increments every non-reset cycle.
  - `ins_cnt` increments on every `PCWrite`.
  - Both wrap at 2^32−1→0 and clear on reset.
- When undefined, neither the ports nor the registers exist.

Decomposition:
- Shared package `mc_pkg`:
  - state encodings;
  - the `itype` enum (ADDU, SUBU, ORI, LUI, LW, SW, BEQ, JAL, JR, NOP, ILL);
  - opcode/func constants;
  - ALUop/NPCop/MemtoReg/RegDst encodings.
- One sub-module, `mc_decode`: purely combinational opcode/func→`itype` classification. The FSM and output decode stay in `mc_ctrl`.

Test Plan:
- `reset`=1 for 2 cycles, then release → `state`=0, `IRWrite`=1 in the first post-reset cycle, all other enables 0.
- addu (op 0, func 0x21) → `state` sequence 0,1,2,4,0; WB cycle has `RegWrite`=1, `RegDst`=01, `MemtoReg`=00, `PCWrite`=1.
- lw (op 0x23) → states 0,1,2,3,4; WB has `MemtoReg`=01, `ALU_SRC`=1, `EXTop`=1. sw (op 0x2b) → `MemRead`=1 only in MEM, no `RegWrite`.
- beq (op 0x04) with `ZERO`=1 → EXEC `NPCop`=01. With `ZERO`=0 → `NPCop`=00. Both 3 cycles.
- jal (op 0x03) → EXEC `RegDst`=10, `MemtoReg`=10, `NPCop`=10. jr (op 0, func 0x08) → `NPCop`=11. op 0x3f → `illegal` pulse in DECODE, `PCWrite`=1, back to FETCH.
- `reset` asserted during the MEM state of sw → `MemRead`=0 in that cycle, `state`=0 on the next edge; with `MC_CTRL_PERF_EN`, both counters read 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, instruction
// classes, opcode/funct constants and datapath select codes.
package mc_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    IT_ADDU, IT_SUBU, IT_ORI, IT_LUI, IT_LW, IT_SW,
    IT_BEQ, IT_JAL, IT_JR, IT_NOP, IT_ILL
  } itype_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                              OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                              OP_JAL = 6'h03;
  localparam logic [OP_W-1:0] FN_NOP = 6'h00, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
                              FN_JR = 6'h08;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_OR = 4'd2,
                                 ALU_LUI = 4'd3;
  localparam logic [SEL_W-1:0] NPC_SEQ = 2'b00, NPC_BR = 2'b01, NPC_JAL = 2'b10,
                               NPC_JR = 2'b11;
  localparam logic [SEL_W-1:0] M2R_ALU = 2'b00, M2R_DM = 2'b01, M2R_PC4 = 2'b10;
  localparam logic [SEL_W-1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;

  typedef struct packed {
    logic               pc_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_read;
    logic [SEL_W-1:0]   mem_to_reg;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic [SEL_W-1:0]   reg_dst;
    logic [SEL_W-1:0]   npc_op;
    logic               ext_op;
    logic               illegal;
  } ctrl_t;

  typedef struct packed {
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               ext_op;
  } alu_t;

  // ALU operand/extension selects for an instruction class, held EXEC..WB
  function automatic alu_t alu_sel(input itype_t it);
    alu_t a;
    a = '0;
    case (it)
      IT_ADDU: a.alu_op = ALU_ADD;
      IT_SUBU: a.alu_op = ALU_SUB;
      IT_ORI:  begin a.alu_src = 1'b1; a.alu_op = ALU_OR;  end
      IT_LUI:  begin a.alu_src = 1'b1; a.alu_op = ALU_LUI; end
      IT_LW, IT_SW: begin a.alu_src = 1'b1; a.alu_op = ALU_ADD; a.ext_op = 1'b1; end
      IT_BEQ:  begin a.alu_op = ALU_SUB; a.ext_op = 1'b1; end
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier producing the instruction class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [3:0] itype_c
);

  always_comb begin
    itype_c = IT_ILL;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADDU: itype_c = IT_ADDU;
          FN_SUBU: itype_c = IT_SUBU;
          FN_JR:   itype_c = IT_JR;
          FN_NOP:  itype_c = IT_NOP;
          default: itype_c = IT_ILL;
        endcase
      end
      OP_ORI:  itype_c = IT_ORI;
      OP_LUI:  itype_c = IT_LUI;
      OP_LW:   itype_c = IT_LW;
      OP_SW:   itype_c = IT_SW;
      OP_BEQ:  itype_c = IT_BEQ;
      OP_JAL:  itype_c = IT_JAL;
      default: itype_c = IT_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the single-issue datapath.
// Define MC_CTRL_PERF_EN to add cycle and retired-instruction counters.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Instruction_class,
  input  logic [5:0] func,
  input  logic       ZERO,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic [1:0] MemtoReg,
  output logic       ALU_SRC,
  output logic [3:0] ALUop,
  output logic [1:0] RegDst,
  output logic [1:0] NPCop,
  output logic       EXTop,
  output logic       newsign,
  output logic [2:0] state,
  output logic       illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ins_cnt
`endif
);

  state_t     state_q, state_d;
  itype_t     itype_q, itype_d;
  itype_t     dec_itype;
  logic [3:0] dec_raw;
  logic       dec_skip;
  ctrl_t      ctrl_c;
  alu_t       alu_c;

  mc_decode u_decode (
    .opcode  (Instruction_class),
    .func    (func),
    .itype_c (dec_raw)
  );

  assign dec_itype = itype_t'(dec_raw);
  assign dec_skip  = (dec_itype == IT_NOP) || (dec_itype == IT_ILL);
  assign alu_c     = alu_sel(itype_q);

  // Next state and instruction-class latch
  always_comb begin
    state_d = ST_FETCH;
    itype_d = itype_q;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        itype_d = dec_itype;
        state_d = dec_skip ? ST_FETCH : ST_EXEC;
      end
      ST_EXEC: begin
        case (itype_q)
          IT_LW, IT_SW:                    state_d = ST_MEM;
          IT_ADDU, IT_SUBU, IT_ORI, IT_LUI: state_d = ST_WB;
          default:                         state_d = ST_FETCH;
        endcase
      end
      ST_MEM:  state_d = (itype_q == IT_LW) ? ST_WB : ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= state_t'(RESET_STATE);
      itype_q <= IT_NOP;
    end else begin
      state_q <= state_d;
      itype_q <= itype_d;
    end
  end

  // Control decode from current state; reset forces everything quiet
  always_comb begin
    ctrl_c = '0;
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      ctrl_c.alu_src = alu_c.alu_src;
      ctrl_c.alu_op  = alu_c.alu_op;
      ctrl_c.ext_op  = alu_c.ext_op;
    end
    case (state_q)
      ST_FETCH:  ctrl_c.ir_write = 1'b1;
      ST_DECODE: begin
        if (dec_skip) begin
          ctrl_c.pc_write = 1'b1;
          ctrl_c.npc_op   = NPC_SEQ;
          ctrl_c.illegal  = (dec_itype == IT_ILL);
        end
      end
      ST_EXEC: begin
        case (itype_q)
          IT_BEQ: begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.npc_op   = ZERO ? NPC_BR : NPC_SEQ;
          end
          IT_JAL: begin
            ctrl_c.reg_write  = 1'b1;
            ctrl_c.reg_dst    = RD_RA;
            ctrl_c.mem_to_reg = M2R_PC4;
            ctrl_c.pc_write   = 1'b1;
            ctrl_c.npc_op     = NPC_JAL;
          end
          IT_JR: begin
            ctrl_c.pc_write = 1'b1;
            ctrl_c.npc_op   = NPC_JR;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        if (itype_q == IT_SW) begin
          ctrl_c.mem_read = 1'b1;
          ctrl_c.pc_write = 1'b1;
          ctrl_c.npc_op   = NPC_SEQ;
        end
      end
      ST_WB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.pc_write   = 1'b1;
        ctrl_c.npc_op     = NPC_SEQ;
        ctrl_c.reg_dst    = (itype_q == IT_ADDU || itype_q == IT_SUBU) ? RD_RD : RD_RT;
        ctrl_c.mem_to_reg = (itype_q == IT_LW) ? M2R_DM : M2R_ALU;
      end
      default: ;
    endcase
    if (reset) ctrl_c = '0;
  end

  assign PCWrite  = ctrl_c.pc_write;
  assign IRWrite  = ctrl_c.ir_write;
  assign RegWrite = ctrl_c.reg_write;
  assign MemRead  = ctrl_c.mem_read;
  assign MemtoReg = ctrl_c.mem_to_reg;
  assign ALU_SRC  = ctrl_c.alu_src;
  assign ALUop    = ctrl_c.alu_op;
  assign RegDst   = ctrl_c.reg_dst;
  assign NPCop    = ctrl_c.npc_op;
  assign EXTop    = ctrl_c.ext_op;
  assign illegal  = ctrl_c.illegal;
  assign newsign  = 1'b0;
  assign state    = state_q;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    ins_d = ins_q + 32'(ctrl_c.pc_write);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`endif

endmodule
